// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry, field widths and arbiter FSM encoding
package vga_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COL_W    = 9;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // True when the coordinate lands inside the visible frame.
  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
  endfunction

endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// rtl/plot_arbiter_rr_pick.sv - round-robin requester pick starting at a pointer
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             valid
);

  // Scan requesters beginning at start (one past the last owner), wrapping once.
  always_comb begin
    int j;
    j        = 0;
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(start) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - arbitrates pixel requesters and full-screen clears onto one plot port
module plot_arbiter
  import vga_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*X_W-1:0]   x_in,
  input  logic [NREQ*Y_W-1:0]   y_in,
  input  logic [NREQ*COL_W-1:0] colour_in,
  output logic [NREQ-1:0]       gnt,
  input  logic                  clear_start,
  input  logic [COL_W-1:0]      clear_colour,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [X_W-1:0]        oX,
  output logic [Y_W-1:0]        oY,
  output logic [COL_W-1:0]      oColour,
  output logic                  oPlot
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [X_W-1:0]   X_LAST  = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(SCREEN_H - 1);

  state_t             state, state_n;
  logic [NREQ-1:0]    gnt_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic               pend, pend_n;
  logic [COL_W-1:0]   clr_col, clr_col_n;
  logic [X_W-1:0]     cx, cx_n, ox_n;
  logic [Y_W-1:0]     cy, cy_n, oy_n;
  logic [COL_W-1:0]   ocol_n;
  logic               plot_n, done_n;

  logic [NREQ-1:0]    pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               clear_take;
  logic               own_req;
  logic               others;
  logic [X_W-1:0]     own_x;
  logic [Y_W-1:0]     own_y;
  logic [COL_W-1:0]   own_col;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .start    (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  assign own_x   = x_in[owner*X_W +: X_W];
  assign own_y   = y_in[owner*Y_W +: Y_W];
  assign own_col = colour_in[owner*COL_W +: COL_W];
  assign own_req = req[owner];
  assign others  = |(req & ~gnt);
  assign cnt_inc = (cnt == MAX_CNT) ? cnt : cnt + 1'b1;

  // A new clear is only taken when none is queued or running.
  assign clear_take = clear_start && !pend && (state != ST_CLEAR);

  // Busy spans the queued period, the fill itself and the final pixel cycle.
  assign clear_busy = pend || (state == ST_CLEAR) || clear_done;

  // Next-state and next-output decode; every register holds unless changed below.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    owner_n   = owner;
    ptr_n     = ptr;
    cnt_n     = cnt;
    pend_n    = pend;
    clr_col_n = clr_col;
    cx_n      = cx;
    cy_n      = cy;
    ox_n      = oX;
    oy_n      = oY;
    ocol_n    = oColour;
    plot_n    = 1'b0;
    done_n    = 1'b0;

    if (clear_take) begin
      pend_n    = 1'b1;
      clr_col_n = clear_colour;
    end

    case (state)
      ST_IDLE: begin
        if (pend || clear_take) begin
          state_n = ST_CLEAR;
          pend_n  = 1'b0;
          cx_n    = '0;
          cy_n    = '0;
        end else if (pick_valid) begin
          state_n = ST_BURST;
          gnt_n   = pick;
          owner_n = pick_idx;
          ptr_n   = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
          cnt_n   = '0;
        end
      end

      ST_CLEAR: begin
        plot_n = 1'b1;
        ox_n   = cx;
        oy_n   = cy;
        ocol_n = clr_col;
        if (cx == X_LAST && cy == Y_LAST) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else if (cx == X_LAST) begin
          cx_n = '0;
          cy_n = cy + 1'b1;
        end else begin
          cx_n = cx + 1'b1;
        end
      end

      ST_BURST: begin
        if (!own_req) begin
          state_n = ST_IDLE;
          gnt_n   = '0;
        end else begin
          if (on_screen(own_x, own_y)) begin
            plot_n = 1'b1;
            ox_n   = own_x;
            oy_n   = own_y;
            ocol_n = own_col;
          end
          cnt_n = cnt_inc;
          if (cnt_inc == MAX_CNT && others) begin
            state_n = ST_IDLE;
            gnt_n   = '0;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      owner      <= '0;
      ptr        <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      clr_col    <= '0;
      cx         <= '0;
      cy         <= '0;
      oX         <= '0;
      oY         <= '0;
      oColour    <= '0;
      oPlot      <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      owner      <= owner_n;
      ptr        <= ptr_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      clr_col    <= clr_col_n;
      cx         <= cx_n;
      cy         <= cy_n;
      oX         <= ox_n;
      oY         <= oy_n;
      oColour    <= ocol_n;
      oPlot      <= plot_n;
      clear_done <= done_n;
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// tb/tb_plot_arbiter.sv - self-checking bench for plot_arbiter
module tb_plot_arbiter;

  localparam int NREQ = 3;
  localparam int MB   = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    req = '0;
  logic [23:0]   x_in = '0;
  logic [20:0]   y_in = '0;
  logic [26:0]   colour_in = '0;
  logic [2:0]    gnt;
  logic          clear_start = 1'b0;
  logic [8:0]    clear_colour = '0;
  logic          clear_busy;
  logic          clear_done;
  logic [7:0]    oX;
  logic [6:0]    oY;
  logic [8:0]    oColour;
  logic          oPlot;

  int checks = 0;
  int failures = 0;

  plot_arbiter #(.NREQ(NREQ), .MAX_BURST(MB)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .x_in         (x_in),
    .y_in         (y_in),
    .colour_in    (colour_in),
    .gnt          (gnt),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .oX           (oX),
    .oY           (oY),
    .oColour      (oColour),
    .oPlot        (oPlot)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0] req;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] c;
    logic [2:0] g;
    logic       p;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [8:0] ec;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic same_pixel(input logic [7:0] x, input logic [6:0] y, input logic [8:0] c);
    x_in      = {3{x}};
    y_in      = {3{y}};
    colour_in = {3{c}};
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    req         = '0;
    clear_start = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [2:0] owner_mask(input int own);
    return (own < 0) ? 3'b000 : 3'(1 << own);
  endfunction

  initial begin
    int own, ptr, cnt, np, j, n, bad, badg, dones, plots;
    logic ep, done_ok, took;
    logic [7:0] ex, rx[3];
    logic [6:0] ey, ry[3];
    logic [8:0] ec, rc[3];
    logic [2:0] r, g, prev;
    int order[$];
    logic [2:0] exp_mb[8];

    tbl[0]  = '{3'b001, 8'd10,  7'd20,  9'h1FF, 3'b000, 1'b0, 8'd0,   7'd0,   9'h000};
    tbl[1]  = '{3'b001, 8'd10,  7'd20,  9'h1FF, 3'b001, 1'b0, 8'd0,   7'd0,   9'h000};
    tbl[2]  = '{3'b001, 8'd10,  7'd20,  9'h1FF, 3'b001, 1'b1, 8'd10,  7'd20,  9'h1FF};
    tbl[3]  = '{3'b001, 8'd10,  7'd20,  9'h1FF, 3'b001, 1'b1, 8'd10,  7'd20,  9'h1FF};
    tbl[4]  = '{3'b000, 8'd10,  7'd20,  9'h1FF, 3'b001, 1'b1, 8'd10,  7'd20,  9'h1FF};
    tbl[5]  = '{3'b000, 8'd10,  7'd20,  9'h1FF, 3'b000, 1'b0, 8'd10,  7'd20,  9'h1FF};
    tbl[6]  = '{3'b100, 8'd160, 7'd5,   9'h0AA, 3'b000, 1'b0, 8'd10,  7'd20,  9'h1FF};
    tbl[7]  = '{3'b100, 8'd160, 7'd5,   9'h0AA, 3'b100, 1'b0, 8'd10,  7'd20,  9'h1FF};
    tbl[8]  = '{3'b100, 8'd159, 7'd119, 9'h055, 3'b100, 1'b0, 8'd10,  7'd20,  9'h1FF};
    tbl[9]  = '{3'b000, 8'd159, 7'd119, 9'h055, 3'b100, 1'b1, 8'd159, 7'd119, 9'h055};
    tbl[10] = '{3'b000, 8'd159, 7'd119, 9'h055, 3'b000, 1'b0, 8'd159, 7'd119, 9'h055};

    // Directed table: single-requester burst, then off-screen and corner pixels.
    do_reset();
    check("reset_busy", 32'(clear_busy), 0);
    check("reset_done", 32'(clear_done), 0);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].g));
      check($sformatf("tbl%0d_plot", i), 32'(oPlot), 32'(tbl[i].p));
      check($sformatf("tbl%0d_x", i), 32'(oX), 32'(tbl[i].ex));
      check($sformatf("tbl%0d_y", i), 32'(oY), 32'(tbl[i].ey));
      check($sformatf("tbl%0d_col", i), 32'(oColour), 32'(tbl[i].ec));
      req = tbl[i].req;
      same_pixel(tbl[i].x, tbl[i].y, tbl[i].c);
      step();
    end

    // Round-robin order with every requester dropping after one pixel.
    same_pixel(8'd1, 7'd2, 9'h003);
    prev = '0;
    took = 1'b0;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      g = gnt;
      if (g != 0 && prev == 0) begin
        order.push_back(g[0] ? 0 : (g[1] ? 1 : 2));
        took = 1'b0;
      end
      r = 3'b111;
      if (g != 0 && took) r = r & ~g;
      if (g != 0) took = 1'b1;
      req  = r;
      prev = g;
      step();
    end
    check("rr_order_len", 32'(order.size()), 4);
    if (order.size() == 4) begin
      check("rr_order0", 32'(order[0]), 0);
      check("rr_order1", 32'(order[1]), 1);
      check("rr_order2", 32'(order[2]), 2);
      check("rr_order3", 32'(order[3]), 0);
    end

    // Forced rotation after MB pixels with a competitor waiting.
    exp_mb = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010};
    do_reset();
    req = 3'b011;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("mb_rot_c%0d", c), 32'(gnt), 32'(exp_mb[c]));
      step();
    end
    // Saturation: lone requester keeps the grant past MB pixels.
    do_reset();
    req = 3'b001;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("mb_hold_c%0d", c), 32'(gnt), (c == 0) ? 0 : 1);
      step();
    end

    // Randomized traffic against a rule-level reference model.
    do_reset();
    own = -1; ptr = 0; cnt = 0; ep = 1'b0; ex = '0; ey = '0; ec = '0;
    for (int c = 0; c < 3000; c++) begin
      check("rnd_gnt", 32'(gnt), 32'(owner_mask(own)));
      check("rnd_onehot", 32'($onehot0(gnt)), 1);
      check("rnd_plot", 32'(oPlot), 32'(ep));
      check("rnd_x", 32'(oX), 32'(ex));
      check("rnd_y", 32'(oY), 32'(ey));
      check("rnd_col", 32'(oColour), 32'(ec));
      r = 3'($urandom_range(0, 7));
      if (own >= 0) r[own] = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < 3; k++) begin
        rx[k] = 8'($urandom_range(0, 175));
        ry[k] = 7'($urandom_range(0, 127));
        rc[k] = 9'($urandom);
      end
      req       = r;
      x_in      = {rx[2], rx[1], rx[0]};
      y_in      = {ry[2], ry[1], ry[0]};
      colour_in = {rc[2], rc[1], rc[0]};
      ep = 1'b0;
      if (own < 0) begin
        np = -1;
        for (int k = 0; k < 3; k++) begin
          j = (ptr + k) % 3;
          if (np < 0 && r[j]) np = j;
        end
        if (np >= 0) begin
          own = np;
          ptr = (np + 1) % 3;
          cnt = 0;
        end
      end else if (r[own]) begin
        if (rx[own] < 160 && ry[own] < 120) begin
          ep = 1'b1;
          ex = rx[own];
          ey = ry[own];
          ec = rc[own];
        end
        cnt = (cnt < MB) ? cnt + 1 : MB;
        if (cnt == MB && (r & ~owner_mask(own)) != 0) own = -1;
      end else begin
        own = -1;
      end
      step();
    end

    // Clear requested mid-burst: burst finishes, then the full fill runs.
    do_reset();
    req = 3'b001;
    same_pixel(8'd10, 7'd20, 9'h1FF);
    step();
    step();
    step();
    clear_start  = 1'b1;
    clear_colour = 9'h000;
    step();
    clear_start = 1'b0;
    check("clr_pending_busy", 32'(clear_busy), 1);
    check("clr_no_preempt0", 32'(gnt), 1);
    step();
    step();
    check("clr_no_preempt1", 32'(gnt), 1);
    req = 3'b000;
    step();
    n = 0; bad = 0; badg = 0; dones = 0; done_ok = 1'b0;
    clear_colour = 9'h1FF;
    for (int c = 0; c < 19400; c++) begin
      if (dones > 0 && !clear_done) break;
      if (gnt != 0) badg++;
      if (oPlot) begin
        if (int'(oX) != n % 160 || int'(oY) != n / 160 || oColour != 9'h000) bad++;
        n++;
      end
      if (clear_done) begin
        dones++;
        if (oPlot && oX == 8'd159 && oY == 7'd119 && n == 19200) done_ok = 1'b1;
      end
      clear_start = (n == 7000);
      step();
    end
    clear_start = 1'b0;
    check("clr_pixel_count", 32'(n), 19200);
    check("clr_pixel_errors", 32'(bad), 0);
    check("clr_gnt_nonzero", 32'(badg), 0);
    check("clr_done_count", 32'(dones), 1);
    check("clr_done_at_last", 32'(done_ok), 1);
    check("clr_busy_after", 32'(clear_busy), 0);

    // Reset in the middle of a clear aborts it.
    do_reset();
    clear_colour = 9'h0AA;
    clear_start  = 1'b1;
    step();
    clear_start = 1'b0;
    n = 0;
    for (int c = 0; c < 6000; c++) begin
      if (oPlot) n++;
      if (n == 5000) break;
      step();
    end
    check("rst_mid_reached", 32'(n), 5000);
    check("rst_mid_busy", 32'(clear_busy), 1);
    reset = 1'b1;
    step();
    check("rst_abort_plot", 32'(oPlot), 0);
    check("rst_abort_busy", 32'(clear_busy), 0);
    check("rst_abort_done", 32'(clear_done), 0);
    reset = 1'b0;
    plots = 0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (oPlot) plots++;
      if (clear_done) dones++;
      step();
    end
    check("rst_after_plots", 32'(plots), 0);
    check("rst_after_dones", 32'(dones), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
